// File: rtl/iir_coeff_sequencer.sv
// Preset Q2.14 coefficient banks for the time-multiplexed IIR accumulator.
// A selected bank is copied to the outputs atomically at the next sample boundary.
module iir_coeff_sequencer #(
    parameter int NUM_SETS = 4,
    parameter int COEF_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        l_r_clk,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_SETS)-1:0] wr_set,
    input  logic [2:0]                  wr_idx,
    input  logic [COEF_W-1:0]           wr_data,
    input  logic                        sel_valid,
    input  logic [$clog2(NUM_SETS)-1:0] sel_set,
    output logic                        sel_ready,
    output logic signed [COEF_W-1:0]    b0,
    output logic signed [COEF_W-1:0]    b1,
    output logic signed [COEF_W-1:0]    b2,
    output logic signed [COEF_W-1:0]    a1,
    output logic signed [COEF_W-1:0]    a2,
    output logic [$clog2(NUM_SETS)-1:0] active_set,
    output logic                        pending,
    output logic                        coef_update
);

    localparam int SW = $clog2(NUM_SETS);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              lr_q, lr_d;
    logic [SW-1:0]     pend_set_q, pend_set_d;
    logic [SW-1:0]     active_q, active_d;
    logic              upd_q, upd_d;
    logic [COEF_W-1:0] coef_q [5];
    logic [COEF_W-1:0] coef_d [5];
    logic [COEF_W-1:0] bank_q [NUM_SETS][5];
    logic [COEF_W-1:0] bank_d [NUM_SETS][5];
    logic              boundary;

    assign boundary = l_r_clk & ~lr_q;

    // Bank storage update; writes never touch the active outputs.
    always_comb begin
        bank_d = bank_q;
        if (wr_en && (wr_idx <= 3'd4)) begin
            bank_d[wr_set][wr_idx] = wr_data;
        end
    end

    // Select handshake, boundary wait and atomic copy of the pending bank.
    always_comb begin
        state_d    = state_q;
        lr_d       = l_r_clk;
        pend_set_d = pend_set_q;
        active_d   = active_q;
        coef_d     = coef_q;
        upd_d      = 1'b0;
        sel_ready  = 1'b0;
        pending    = 1'b0;
        case (state_q)
            IDLE: begin
                sel_ready = 1'b1;
                if (sel_valid) begin
                    pend_set_d = sel_set;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                pending = 1'b1;
                if (boundary) begin
                    coef_d   = bank_q[pend_set_q];
                    active_d = pend_set_q;
                    upd_d    = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control and coefficient registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lr_q       <= 1'b1;
            pend_set_q <= '0;
            active_q   <= '0;
            upd_q      <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                coef_q[i] <= '0;
            end
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int i = 0; i < 5; i++) begin
                    bank_q[s][i] <= '0;
                end
            end
        end else begin
            state_q    <= state_d;
            lr_q       <= lr_d;
            pend_set_q <= pend_set_d;
            active_q   <= active_d;
            upd_q      <= upd_d;
            coef_q     <= coef_d;
            bank_q     <= bank_d;
        end
    end

    assign b0          = coef_q[0];
    assign b1          = coef_q[1];
    assign b2          = coef_q[2];
    assign a1          = coef_q[3];
    assign a2          = coef_q[4];
    assign active_set  = active_q;
    assign coef_update = upd_q;

endmodule
